// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 selector between four requesters.
// The granted source word is registered onto sout one cycle after its grant.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   req[3:0]        request lines, bit i belongs to source Pi
//   P0..P3          WIDTH-bit source words
//   grant[3:0]      registered one-hot grant, zero when idle
//   sel[1:0]        registered select code of the current owner
//   sout            registered shared output word
//   sout_valid      sout holds a word sampled under a grant
//   busy            arbiter is in the GRANT state
//
// Build option: define MUX4_ARB_FIXED_PRIO_EN to replace the rotating pick
// with lowest-index-wins fixed priority (hold limit still applies).
module mux4_rr_arbiter #(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] P0,
    input  logic [WIDTH-1:0] P1,
    input  logic [WIDTH-1:0] P2,
    input  logic [WIDTH-1:0] P3,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] sout,
    output logic             sout_valid,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state;
    state_t           state_n;
    logic [3:0]       grant_n;
    logic [1:0]       sel_n;
    logic [1:0]       ptr;
    logic [1:0]       ptr_n;
    logic [3:0]       hold_cnt;
    logic [3:0]       hold_n;
    logic [3:0]       others;
    logic [1:0]       nxt;
    logic [WIDTH-1:0] pmux;

`ifdef MUX4_ARB_FIXED_PRIO_EN
    // Lowest set index wins; the pointer is only a don't-care default.
    function automatic logic [1:0] pick(
        input logic [3:0] r,
        input logic [1:0] last
    );
        pick = last;
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) begin
                pick = 2'(i);
            end
        end
    endfunction
`else
    // Cyclic scan starting just after the last owner.
    function automatic logic [1:0] pick(
        input logic [3:0] r,
        input logic [1:0] last
    );
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction
`endif

    // In IDLE grant is zero, so "others" is simply req. In GRANT it is
    // every waiting requester except the owner; since ptr equals the owner
    // there, one scan covers fresh picks, early release and forced rotation.
    assign others = req & ~grant;
    assign nxt    = pick(others, ptr);
    assign busy   = (state == GRANT);

    always_comb begin
        pmux = P0;
        unique case (sel)
            2'd0: pmux = P0;
            2'd1: pmux = P1;
            2'd2: pmux = P2;
            2'd3: pmux = P3;
        endcase
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    grant_n = 4'b0001 << nxt;
                    sel_n   = nxt;
                    ptr_n   = nxt;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    if (|others) begin
                        grant_n = 4'b0001 << nxt;
                        sel_n   = nxt;
                        ptr_n   = nxt;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                    hold_n = '0;
                end else if (|others) begin
                    if (hold_cnt == HOLD_LAST) begin
                        grant_n = 4'b0001 << nxt;
                        sel_n   = nxt;
                        ptr_n   = nxt;
                        hold_n  = '0;
                    end else if (hold_cnt < HOLD_LAST) begin
                        hold_n = hold_cnt + 4'd1;
                    end
                end else begin
                    hold_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            ptr      <= 2'd3;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            sel      <= sel_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    // Data path uses the owner from before the edge, so it trails grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout       <= '0;
            sout_valid <= 1'b0;
        end else begin
            sout_valid <= (state == GRANT);
            if (state == GRANT) begin
                sout <= pmux;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table, corner sequences
// and random traffic compared against a behavioural model.
module tb_mux4_rr_arbiter;

    localparam int W    = 2;
    localparam int MAXH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] P0, P1, P2, P3;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic [W-1:0] sout;
    logic         sout_valid;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .P0(P0), .P1(P1), .P2(P2), .P3(P3),
        .grant(grant), .sel(sel), .sout(sout),
        .sout_valid(sout_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic [1:0] sout;
        logic       valid;
        logic       busy;
    } vec_t;

    // Reference model: owner index (-1 = idle), last owner, hold count.
    int           m_owner;
    int           m_ptr;
    int           m_hold;
    int           m_sel;
    logic [W-1:0] m_sout;
    logic         m_valid;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int m_pick(input logic [3:0] r, input int last);
`ifdef MUX4_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (r[i]) return i;
        end
`endif
        return last;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_hold  = 0;
        m_sel   = 0;
        m_sout  = '0;
        m_valid = 1'b0;
    endtask

    task automatic take(input int w);
        m_owner = w;
        m_sel   = w;
        m_ptr   = w;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [W-1:0] pv [4];
        logic [3:0]   oth;
        pv[0] = P0; pv[1] = P1; pv[2] = P2; pv[3] = P3;
        if (m_owner >= 0) begin
            m_sout  = pv[m_sel];
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (m_owner < 0) begin
            if (r != 0) take(m_pick(r, m_ptr));
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                if (oth != 0) take(m_pick(oth, m_ptr));
                else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (oth != 0) begin
                if (m_hold == MAXH - 1) take(m_pick(oth, m_ptr));
                else m_hold++;
            end else begin
                m_hold = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_grant"}, 32'(grant),
            m_owner < 0 ? 32'd0 : 32'(1) << m_owner);
        chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
        chk({tag, "_sout"}, 32'(sout), 32'(m_sout));
        chk({tag, "_valid"}, 32'(sout_valid), 32'(m_valid));
        chk({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
    endtask

    task automatic cycle(input logic [3:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        compare_all(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_sel"}, 32'(sel), 0);
        chk({tag, "_sout"}, 32'(sout), 0);
        chk({tag, "_valid"}, 32'(sout_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t tbl [14];
        logic [3:0] r;
        tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 2'd0, 1'b0, 1'b1};
        tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 2'd2, 1'b1, 1'b1};
        tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 2'd2, 1'b1, 1'b1};
        tbl[3]  = '{4'b1111, 4'b0100, 2'd2, 2'd2, 1'b1, 1'b1};
        tbl[4]  = '{4'b1111, 4'b0100, 2'd2, 2'd2, 1'b1, 1'b1};
        tbl[5]  = '{4'b1111, 4'b0100, 2'd2, 2'd2, 1'b1, 1'b1};
        tbl[6]  = '{4'b1111, 4'b1000, 2'd3, 2'd2, 1'b1, 1'b1};
        tbl[7]  = '{4'b1111, 4'b1000, 2'd3, 2'd3, 1'b1, 1'b1};
        tbl[8]  = '{4'b0010, 4'b0010, 2'd1, 2'd3, 1'b1, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 2'd1, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 2'd1, 2'd1, 1'b0, 1'b0};
        tbl[11] = '{4'b1001, 4'b1000, 2'd3, 2'd1, 1'b0, 1'b1};
        tbl[12] = '{4'b0001, 4'b0001, 2'd0, 2'd3, 1'b1, 1'b1};
        tbl[13] = '{4'b0011, 4'b0001, 2'd0, 2'd0, 1'b1, 1'b1};

        rst_n = 1'b0;
        req   = 4'b1111;
        P0 = 2'd0; P1 = 2'd1; P2 = 2'd2; P3 = 2'd3;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1111, "first");
        chk("first_grant_0001", 32'(grant), 32'b0001);

`ifndef MUX4_ARB_FIXED_PRIO_EN
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].req, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("tbl%0d_sout", i), 32'(sout), 32'(tbl[i].sout));
            chk($sformatf("tbl%0d_valid", i), 32'(sout_valid),
                32'(tbl[i].valid));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end

        do_reset();
        for (int c = 1; c <= 20; c++) begin
            cycle(4'b1111, $sformatf("rr%0d", c));
            chk($sformatf("rr%0d_owner", c), 32'(grant),
                32'(1) << (((c - 1) / 4) % 4));
            if (c >= 2)
                chk($sformatf("rr%0d_data", c), 32'(sout),
                    32'(((c - 2) / 4) % 4));
        end
`endif

        do_reset();
        P2 = 2'b10;
        for (int c = 0; c < 10; c++) cycle(4'b0100, "sole");
        chk("sole_grant", 32'(grant), 32'b0100);
        chk("sole_sout", 32'(sout), 32'b10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async");
        model_reset();
        req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b1010, "after_rst");
        chk("after_rst_grant_0010", 32'(grant), 32'b0010);

        r = 4'b1111;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            P0 = W'($urandom);
            P1 = W'($urandom);
            P2 = W'($urandom);
            P3 = W'($urandom);
            cycle(r, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
